// File: rtl/frogger_pkg.sv
// Shared types, geometry constants and arithmetic helpers for the frogger game-state logic.
// Purely combinational helpers; no state lives here.
package frogger_pkg;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HIT  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    localparam logic [10:0] H_DISPLAY   = 11'd640;
    localparam logic [10:0] V_DISPLAY   = 11'd480;
    localparam logic [10:0] PLAYER_SIZE = 11'd32;
    localparam logic [10:0] PLAYER_STEP = 11'd32;
    localparam logic [10:0] START_X     = 11'd304;
    localparam logic [10:0] START_Y     = 11'd448;
    localparam logic [10:0] CAR_W       = 11'd64;
    localparam logic [10:0] CAR_H       = 11'd32;
    localparam logic [10:0] CAR_SPEED   = 11'd2;
    localparam logic [1:0]  START_LIVES = 2'd3;

    localparam logic [10:0] X_MAX = H_DISPLAY - PLAYER_SIZE;
    localparam logic [10:0] Y_MAX = V_DISPLAY - PLAYER_SIZE;

    localparam logic [10:0] LANE1_Y = 11'd96;
    localparam logic [10:0] LANE2_Y = 11'd192;
    localparam logic [10:0] LANE3_Y = 11'd288;
    localparam logic [10:0] LANE4_Y = 11'd384;

    localparam logic [10:0] CAR1_RST_X = 11'd0;
    localparam logic [10:0] CAR2_RST_X = 11'd160;
    localparam logic [10:0] CAR3_RST_X = 11'd320;
    localparam logic [10:0] CAR4_RST_X = 11'd480;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    // Strict AABB test: touching edges do not count as a hit.
    function automatic logic overlap(input logic [10:0] px, input logic [10:0] py,
                                     input logic [10:0] cx, input logic [10:0] cy);
        return (px < cx + CAR_W) && (cx < px + PLAYER_SIZE) &&
               (py < cy + CAR_H) && (cy < py + PLAYER_SIZE);
    endfunction

    function automatic logic [10:0] car_right(input logic [10:0] x, input logic [10:0] spd);
        if (x + spd >= H_DISPLAY) return x + spd - H_DISPLAY;
        return x + spd;
    endfunction

    function automatic logic [10:0] car_left(input logic [10:0] x, input logic [10:0] spd);
        if (x < spd) return x + H_DISPLAY - spd;
        return x - spd;
    endfunction

endpackage

// File: rtl/frogger_game_logic_button_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, one-cycle rising-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 to the pulse; no backpressure, pulse is fire-and-forget.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic btn_async,
    output logic rise_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_async;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        // Any sample agreeing with the current level restarts the count.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) db_d  = sync2_q;
            else                   cnt_d = cnt_q + 1'b1;
        end
        rise_d = db_d & ~db_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/frogger_game_logic.sv
// Frogger game state (player, cars, lives, level), updated once per frame at start of vertical blank.
// Latency: outputs change 2 cycles after h_count==0/v_count==V_DISPLAY; no backpressure. Macro LEVEL_SPEEDUP_EN adds level to car speed.
module frogger_game_logic
    import frogger_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HIT_FRAMES      = 60
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       SW_UP,
    input  logic       SW_DOWN,
    input  logic       SW_LEFT,
    input  logic       SW_RIGHT,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic [9:0] car1_x,
    output logic [9:0] car2_x,
    output logic [9:0] car3_x,
    output logic [9:0] car4_x,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic [1:0] state_o
);

    localparam int HW = (HIT_FRAMES > 2) ? $clog2(HIT_FRAMES) : 1;
    localparam logic [HW-1:0] HIT_LAST = HW'(HIT_FRAMES - 1);

    logic [3:0]        btn_raw, btn_rise;
    logic [3:0][10:0]  lane_y;
    logic              tick_q, tick_d;
    logic [3:0]        pend_q, pend_d;
    logic [9:0]        px_q, px_d, py_q, py_d;
    logic [3:0][9:0]   car_q, car_d;
    logic [1:0]        lives_q, lives_d;
    logic [2:0]        level_q, level_d;
    logic [HW-1:0]     hcnt_q, hcnt_d;
    state_e            state_q, state_d;

    logic [10:0] px, py, nx, ny, spd, step_x;
    logic        hit;

    assign btn_raw = {SW_RIGHT, SW_LEFT, SW_DOWN, SW_UP};
    assign lane_y  = {LANE4_Y, LANE3_Y, LANE2_Y, LANE1_Y};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .btn_async (btn_raw[g]),
            .rise_o    (btn_rise[g])
        );
    end

    always_comb begin
        tick_d  = (h_count == 10'd0) && (v_count == V_DISPLAY[9:0]);
        pend_d  = (tick_q ? 4'b0000 : pend_q) | btn_rise;
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        car_d   = car_q;
        lives_d = lives_q;
        level_d = level_q;
        hcnt_d  = hcnt_q;
        px      = {1'b0, px_q};
        py      = {1'b0, py_q};
        nx      = px;
        ny      = py;
        step_x  = '0;
`ifdef LEVEL_SPEEDUP_EN
        spd     = CAR_SPEED + {8'd0, level_q};
`else
        spd     = CAR_SPEED;
`endif
        hit = 1'b0;
        for (int i = 0; i < 4; i++) hit = hit | overlap(px, py, {1'b0, car_q[i]}, lane_y[i]);

        // Out-of-field moves are discarded rather than clamped.
        if (pend_q[BTN_UP]) begin
            if (py >= PLAYER_STEP) ny = py - PLAYER_STEP;
        end else if (pend_q[BTN_DOWN]) begin
            if (py + PLAYER_STEP <= Y_MAX) ny = py + PLAYER_STEP;
        end else if (pend_q[BTN_LEFT]) begin
            if (px >= PLAYER_STEP) nx = px - PLAYER_STEP;
        end else if (pend_q[BTN_RIGHT]) begin
            if (px + PLAYER_STEP <= X_MAX) nx = px + PLAYER_STEP;
        end

        if (tick_q) begin
            if (state_q != ST_OVER) begin
                for (int i = 0; i < 4; i++) begin
                    step_x   = (i % 2 == 0) ? car_right({1'b0, car_q[i]}, spd)
                                            : car_left({1'b0, car_q[i]}, spd);
                    car_d[i] = step_x[9:0];
                end
            end
            case (state_q)
                ST_PLAY: begin
                    if (hit) begin
                        state_d = ST_HIT;
                        hcnt_d  = '0;
                    end else if (ny == 11'd0) begin
                        level_d = (level_q == 3'd7) ? 3'd7 : level_q + 3'd1;
                        px_d    = START_X[9:0];
                        py_d    = START_Y[9:0];
                    end else begin
                        px_d = nx[9:0];
                        py_d = ny[9:0];
                    end
                end
                ST_HIT: begin
                    if (hcnt_q == HIT_LAST) begin
                        lives_d = lives_q - 2'd1;
                        px_d    = START_X[9:0];
                        py_d    = START_Y[9:0];
                        hcnt_d  = '0;
                        state_d = (lives_q == 2'd1) ? ST_OVER : ST_PLAY;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                ST_OVER: begin
                    if (|pend_q) begin
                        lives_d = START_LIVES;
                        level_d = 3'd0;
                        px_d    = START_X[9:0];
                        py_d    = START_Y[9:0];
                        state_d = ST_PLAY;
                    end
                end
                default: state_d = ST_PLAY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_q  <= 1'b0;
            pend_q  <= '0;
            px_q    <= START_X[9:0];
            py_q    <= START_Y[9:0];
            car_q   <= {CAR4_RST_X[9:0], CAR3_RST_X[9:0], CAR2_RST_X[9:0], CAR1_RST_X[9:0]};
            lives_q <= START_LIVES;
            level_q <= 3'd0;
            hcnt_q  <= '0;
            state_q <= ST_PLAY;
        end else begin
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            px_q    <= px_d;
            py_q    <= py_d;
            car_q   <= car_d;
            lives_q <= lives_d;
            level_q <= level_d;
            hcnt_q  <= hcnt_d;
            state_q <= state_d;
        end
    end

    assign player_x = px_q;
    assign player_y = py_q;
    assign car1_x   = car_q[0];
    assign car2_x   = car_q[1];
    assign car3_x   = car_q[2];
    assign car4_x   = car_q[3];
    assign lives    = lives_q;
    assign level    = level_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_frogger_game_logic.sv
// Directed bench for frogger_game_logic: movement, bounds, car wrap, hits, game over, goal row, async reset.
module tb_frogger_game_logic;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [9:0] h_count, v_count;
    logic [3:0] sw;
    logic [9:0] player_x, player_y, car1_x, car2_x, car3_x, car4_x;
    logic [1:0] lives, state_o;
    logic [2:0] level;

    int checks = 0;
    int failures = 0;
    int frames = 0;
    int exp_level = 0;
    int exp_car[4];

    always #20 CLK = ~CLK;

    frogger_game_logic #(.DEBOUNCE_CYCLES(4), .HIT_FRAMES(60)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .h_count  (h_count),
        .v_count  (v_count),
        .SW_UP    (sw[0]),
        .SW_DOWN  (sw[1]),
        .SW_LEFT  (sw[2]),
        .SW_RIGHT (sw[3]),
        .player_x (player_x),
        .player_y (player_y),
        .car1_x   (car1_x),
        .car2_x   (car2_x),
        .car3_x   (car3_x),
        .car4_x   (car4_x),
        .lives    (lives),
        .level    (level),
        .state_o  (state_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_player(input string tag, input int x, input int y);
        check_eq({tag, "_x"}, player_x, x);
        check_eq({tag, "_y"}, player_y, y);
    endtask

    function automatic int next_car(input int li, input int x);
        int spd;
`ifdef LEVEL_SPEEDUP_EN
        spd = 2 + exp_level;
`else
        spd = 2;
`endif
        if (li == 0 || li == 2) return (x + spd) % 640;
        return (x + 640 - spd) % 640;
    endfunction

    function automatic bit unsafe_at_start_x(input int c);
        return (304 < c + 64) && (c < 304 + 32);
    endfunction

    task automatic do_frame(input bit cars_move);
        @(negedge CLK); h_count = 10'd0; v_count = 10'd480;
        @(negedge CLK); h_count = 10'd1; v_count = 10'd0;
        @(negedge CLK);
        @(negedge CLK);
        if (cars_move) for (int i = 0; i < 4; i++) exp_car[i] = next_car(i, exp_car[i]);
        frames++;
    endtask

    task automatic press(input int b);
        sw[b] = 1'b1;
        repeat (10) @(negedge CLK);
        sw[b] = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic glitch(input int b);
        sw[b] = 1'b1;
        repeat (2) @(negedge CLK);
        sw[b] = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    // Walk to lane 4, wait for car4 to hit, then sit out the freeze.
    task automatic hit_cycle(input int lives_before);
        int k;
        press(0); do_frame(1);
        press(0); do_frame(1);
        k = 0;
        while (state_o != 2'd1 && k < 400) begin
            do_frame(1);
            k++;
        end
        check_eq("hitN_enter", state_o, 1);
        repeat (59) do_frame(1);
        check_eq("hitN_hold_state", state_o, 1);
        check_eq("hitN_hold_y", player_y, 384);
        do_frame(1);
        check_eq("hitN_lives", lives, lives_before - 1);
        check_eq("hitN_state", state_o, (lives_before == 1) ? 2 : 0);
        check_player("hitN_respawn", 304, 448);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cur_y, ty, li, k, frozen;
        RST_N = 1'b0;
        h_count = 10'd1;
        v_count = 10'd0;
        sw = 4'b0000;
        exp_car = '{0, 160, 320, 480};
        repeat (3) @(negedge CLK);
        check_player("rst_player", 304, 448);
        check_eq("rst_car1", car1_x, 0);
        check_eq("rst_car2", car2_x, 160);
        check_eq("rst_car3", car3_x, 320);
        check_eq("rst_car4", car4_x, 480);
        check_eq("rst_lives", lives, 3);
        check_eq("rst_level", level, 0);
        check_eq("rst_state", state_o, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        press(0); do_frame(1);
        check_player("up_move", 304, 416);
        check_eq("car1_first_step", car1_x, 2);

        glitch(2); do_frame(1);
        check_player("glitch_ignored", 304, 416);

        press(1); do_frame(1);
        check_player("down_move", 304, 448);
        press(1); do_frame(1);
        check_player("down_at_edge_dropped", 304, 448);
        press(3); do_frame(1);
        check_player("right_move", 336, 448);
        press(2); do_frame(1);
        check_player("left_move", 304, 448);

        while (frames < 320) begin
            do_frame(1);
            if (frames == 80)  check_eq("car2_at_0", car2_x, 0);
            if (frames == 81)  check_eq("car2_wrap", car2_x, 638);
            if (frames == 319) check_eq("car1_at_638", car1_x, 638);
        end
        check_eq("car1_wrap", car1_x, 0);
        check_eq("car2_full_lap", car2_x, 160);
        check_eq("car3_full_lap", car3_x, 320);
        check_eq("car4_full_lap", car4_x, 480);

        repeat (5) begin press(0); do_frame(1); end
        check_player("at_lane3", 304, 288);
        check_eq("at_lane3_state", state_o, 0);
        press(0); do_frame(1);
        check_eq("hit1_enter", state_o, 1);
        check_player("hit1_no_move", 304, 288);
        check_eq("hit1_car3", car3_x, 332);
        repeat (59) do_frame(1);
        check_eq("hit1_hold_state", state_o, 1);
        check_eq("hit1_hold_lives", lives, 3);
        do_frame(1);
        check_eq("hit1_lives", lives, 2);
        check_eq("hit1_state", state_o, 0);
        check_player("hit1_respawn", 304, 448);

        hit_cycle(2);
        hit_cycle(1);
        frozen = exp_car[0];
        check_eq("over_car1", car1_x, frozen);
        do_frame(0);
        check_eq("over_stays", state_o, 2);
        check_eq("over_car1_frozen", car1_x, frozen);
        press(3); do_frame(0);
        check_eq("restart_state", state_o, 0);
        check_eq("restart_lives", lives, 3);
        check_eq("restart_level", level, 0);
        check_player("restart_player", 304, 448);
        check_eq("restart_car1_kept", car1_x, frozen);

        cur_y = 448;
        for (int s = 0; s < 14; s++) begin
            ty = cur_y - 32;
            li = (ty == 96) ? 0 : (ty == 192) ? 1 : (ty == 288) ? 2 : (ty == 384) ? 3 : -1;
            if (li >= 0) begin
                k = 0;
                while (unsafe_at_start_x(next_car(li, exp_car[li])) && k < 400) begin
                    do_frame(1);
                    k++;
                end
            end
            press(0); do_frame(1);
            cur_y = ty;
        end
        exp_level = 1;
        check_eq("goal_level", level, 1);
        check_player("goal_respawn", 304, 448);
        check_eq("goal_state", state_o, 0);
        check_eq("goal_lives", lives, 3);
        check_eq("model_car1_sync", car1_x, exp_car[0]);
        do_frame(1);
        check_eq("lvl1_car1_speed", car1_x, exp_car[0]);
        check_eq("lvl1_car2_speed", car2_x, exp_car[1]);

        press(0); do_frame(1);
        check_player("pre_reset_move", 304, 416);
        @(negedge CLK);
        #5 RST_N = 1'b0;
        #1;
        check_player("async_rst_player", 304, 448);
        check_eq("async_rst_level", level, 0);
        check_eq("async_rst_car1", car1_x, 0);
        check_eq("async_rst_car4", car4_x, 480);
        check_eq("async_rst_lives", lives, 3);
        check_eq("async_rst_state", state_o, 0);
        #5 RST_N = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
